// File: rtl/selection_credit.sv
// selection_credit
//   Per-input-port selection stage that sits after the odd-even routing stage.
//   Each port captures its candidate direction list, and then picks the candidate
//   whose downstream neighbour has the most free credits. It holds that choice as
//   a one-hot switch-allocator request until the packet's tail has left.
//   The block also keeps one free-buffer credit counter for each neighbour (N/E/S/W).
//
// Ports
//   i_clk               clock
//   i_reset             synchronous active-high reset
//   i_select_neighbor   per port: candidate list valid this cycle
//   i_avail_directions  per port: candidate list; entry M-1 is the valid-entry count
//   i_flit_sent         per port: one flit left through the granted output
//   i_tail_sent         per port: that flit was the tail
//   i_credit_return     per neighbour N/E/S/W: one buffer slot freed
//   o_req_valid         per port: request to the switch allocator
//   o_output_req        per port: one-hot output [local, N, E, S, W]
//   o_busy              per port: FSM not idle
//   o_credit            per neighbour: current credit count
//
// Port FSM
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no packet; waits for i_select_neighbor to capture a list
//   ST_SELECT | one cycle: picks a candidate from the captured list, or drops
//             | a list whose count is invalid
//   ST_HOLD   | drives the one-hot request until the tail flit is sent

module selection_credit #(
    parameter int N         = 5,
    parameter int M         = 3,
    parameter int BUF_DEPTH = 4,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [0:N-1]             i_select_neighbor,
    input  logic [0:N-1][0:M-1][1:0] i_avail_directions,
    input  logic [0:N-1]             i_flit_sent,
    input  logic [0:N-1]             i_tail_sent,
    input  logic [0:3]               i_credit_return,
    output logic [0:N-1]             o_req_valid,
    output logic [0:N-1][0:N-1]      o_output_req,
    output logic [0:N-1]             o_busy,
    output logic [0:3][CW-1:0]       o_credit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t                     r_state     [0:N-1];
    state_t                     w_state_nxt [0:N-1];

    logic [0:N-1][0:M-1][1:0]   r_list;
    logic [1:0]                 r_dir       [0:N-1];
    logic [0:N-1]               r_req_valid;
    logic [0:N-1][0:N-1]        r_output_req;
    logic [0:3][CW-1:0]         r_credit;

    logic [0:N-1]               w_count_ok;
    logic [1:0]                 w_pick      [0:N-1];
    logic [0:N-1][0:N-1]        w_onehot;
    logic [0:3]                 w_dec;

    // Next state plus the pick. The pick is computed every cycle, but it is only
    // consumed in ST_SELECT. By then r_credit holds the values that were
    // registered at the start of that cycle.
    always_comb begin
        int         cnt;
        logic [1:0] best;
        cnt  = 0;
        best = 2'd0;
        for (int i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            cnt            = int'(r_list[i][M-1]);
            w_count_ok[i]  = (cnt >= 1) && (cnt <= M - 1);
            best           = r_list[i][0];
            // Strictly-larger compare: on a tie, the earlier entry stays chosen.
            for (int k = 1; k < M - 1; k++) begin
                if ((k < cnt) && (r_credit[r_list[i][k]] > r_credit[best])) begin
                    best = r_list[i][k];
                end
            end
            w_pick[i]                   = best;
            w_onehot[i]                 = '0;
            w_onehot[i][int'(best) + 1] = 1'b1;

            case (r_state[i])
                ST_IDLE: begin
                    if (i_select_neighbor[i]) begin
                        w_state_nxt[i] = ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    w_state_nxt[i] = w_count_ok[i] ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (i_flit_sent[i] && i_tail_sent[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                end
            endcase
        end
    end

    // At most one holder per direction sends per cycle (the allocator guarantees
    // this), so an OR is enough here.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < N; i++) begin
            if ((r_state[i] == ST_HOLD) && i_flit_sent[i]) begin
                w_dec[r_dir[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_req_valid  <= '0;
            r_output_req <= '0;
            for (int d = 0; d < 4; d++) begin
                r_credit[d] <= CW'(BUF_DEPTH);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (i_select_neighbor[i]) begin
                            r_list[i] <= i_avail_directions[i];
                        end
                    end
                    ST_SELECT: begin
                        if (w_count_ok[i]) begin
                            r_dir[i]        <= w_pick[i];
                            r_output_req[i] <= w_onehot[i];
                            r_req_valid[i]  <= (r_credit[w_pick[i]] != '0);
                        end
                    end
                    ST_HOLD: begin
                        if (i_flit_sent[i] && i_tail_sent[i]) begin
                            r_output_req[i] <= '0;
                            r_req_valid[i]  <= 1'b0;
                        end else begin
                            // Registered view of the credit, so it lags a credit change by one cycle.
                            r_req_valid[i] <= (r_credit[r_dir[i]] != '0);
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // A send and a return in the same cycle cancel out. A lone send at 0,
            // or a lone return at BUF_DEPTH, is a protocol error; the counter holds.
            for (int d = 0; d < 4; d++) begin
                if (w_dec[d] && !i_credit_return[d]) begin
                    if (r_credit[d] != '0) begin
                        r_credit[d] <= r_credit[d] - CW'(1);
                    end
                end else if (!w_dec[d] && i_credit_return[d]) begin
                    if (r_credit[d] != CW'(BUF_DEPTH)) begin
                        r_credit[d] <= r_credit[d] + CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_busy[i] = (r_state[i] != ST_IDLE);
        end
    end

    assign o_req_valid  = r_req_valid;
    assign o_output_req = r_output_req;
    assign o_credit     = r_credit;

endmodule

// File: tb/tb_selection_credit.sv
// tb_selection_credit
//   The bench drives directed scenarios and then random traffic into selection_credit.
//   A behavioural model tracks, for each port, whether it is idle, choosing or
//   holding, and it also tracks the neighbour credit counts. When the model makes a
//   pick, the expected one-hot request goes into a scoreboard queue. A monitor on
//   the falling edge pops that entry when the DUT raises a new request. The monitor
//   also compares busy, req_valid and the credits on every cycle.

module tb_selection_credit;

    localparam int N         = 5;
    localparam int M         = 3;
    localparam int BUF_DEPTH = 4;
    localparam int CW        = $clog2(BUF_DEPTH + 1);

    logic                     clk;
    logic                     i_reset;
    logic [0:N-1]             i_select_neighbor;
    logic [0:N-1][0:M-1][1:0] i_avail_directions;
    logic [0:N-1]             i_flit_sent;
    logic [0:N-1]             i_tail_sent;
    logic [0:3]               i_credit_return;
    logic [0:N-1]             o_req_valid;
    logic [0:N-1][0:N-1]      o_output_req;
    logic [0:N-1]             o_busy;
    logic [0:3][CW-1:0]       o_credit;

    selection_credit #(.N(N), .M(M), .BUF_DEPTH(BUF_DEPTH), .CW(CW)) dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_select_neighbor  (i_select_neighbor),
        .i_avail_directions (i_avail_directions),
        .i_flit_sent        (i_flit_sent),
        .i_tail_sent        (i_tail_sent),
        .i_credit_return    (i_credit_return),
        .o_req_valid        (o_req_valid),
        .o_output_req       (o_output_req),
        .o_busy             (o_busy),
        .o_credit           (o_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    typedef struct packed {
        int         port;
        logic [0:4] req;
    } sb_t;
    sb_t sb[$];

    // Model state for each port: waiting to choose, holding, or idle (neither flag set).
    bit m_pend [N];
    bit m_hold [N];
    bit m_rv   [N];
    int m_dir  [N];
    int m_list [N][M-1];
    int m_cnt  [N];
    int m_cred [4];
    bit used   [4];

    task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, p, act, exp);
        end
    endtask

    task automatic model_step();
        int         dec [4];
        int         best;
        logic [0:4] oh;
        if (i_reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_hold[i] = 0; m_rv[i] = 0;
            end
            for (int d = 0; d < 4; d++) m_cred[d] = BUF_DEPTH;
            sb.delete();
            return;
        end
        for (int d = 0; d < 4; d++) dec[d] = 0;
        for (int i = 0; i < N; i++)
            if (m_hold[i] && i_flit_sent[i]) dec[m_dir[i]] = 1;
        for (int i = 0; i < N; i++) begin
            if (m_hold[i]) begin
                if (i_flit_sent[i] && i_tail_sent[i]) begin
                    m_hold[i] = 0; m_rv[i] = 0;
                end else begin
                    m_rv[i] = (m_cred[m_dir[i]] != 0);
                end
            end else if (m_pend[i]) begin
                m_pend[i] = 0;
                if (m_cnt[i] >= 1 && m_cnt[i] <= M - 1) begin
                    best = m_list[i][0];
                    for (int k = 1; k < m_cnt[i]; k++)
                        if (m_cred[m_list[i][k]] > m_cred[best]) best = m_list[i][k];
                    m_hold[i] = 1;
                    m_dir[i]  = best;
                    m_rv[i]   = (m_cred[best] != 0);
                    oh = '0;
                    oh[best + 1] = 1'b1;
                    sb.push_back('{port: i, req: oh});
                end
            end else if (i_select_neighbor[i]) begin
                m_pend[i] = 1;
                for (int k = 0; k < M - 1; k++) m_list[i][k] = int'(i_avail_directions[i][k]);
                m_cnt[i] = int'(i_avail_directions[i][M-1]);
            end
        end
        for (int d = 0; d < 4; d++) begin
            m_cred[d] = m_cred[d] + int'(i_credit_return[d]) - dec[d];
            if (m_cred[d] < 0) m_cred[d] = 0;
            if (m_cred[d] > BUF_DEPTH) m_cred[d] = BUF_DEPTH;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        i_select_neighbor = '0;
        i_flit_sent       = '0;
        i_tail_sent       = '0;
        i_credit_return   = '0;
    endtask

    task automatic sel(input int p, input int e0, input int e1, input int cnt);
        i_select_neighbor[p]     = 1'b1;
        i_avail_directions[p][0] = 2'(e0);
        i_avail_directions[p][1] = 2'(e1);
        i_avail_directions[p][2] = 2'(cnt);
    endtask

    task automatic flit(input int p, input bit tail);
        i_flit_sent[p] = 1'b1;
        i_tail_sent[p] = tail;
    endtask

    task automatic ret(input int d);
        i_credit_return[d] = 1'b1;
    endtask

    // Monitor: a scoreboard for the picks, plus cycle-by-cycle checks of the status outputs.
    logic [0:4] prev [N];
    initial begin
        sb_t e;
        for (int i = 0; i < N; i++) prev[i] = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < N; i++) begin
                    chk("busy", i, 32'(o_busy[i]), 32'(m_pend[i] | m_hold[i]));
                    chk("req_valid", i, 32'(o_req_valid[i]), 32'(m_rv[i]));
                    chk("req_present", i, 32'(o_output_req[i] != '0), 32'(m_hold[i]));
                    if (o_output_req[i] != '0 && o_output_req[i] != prev[i]) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_req", i, 32'(o_output_req[i]), 32'(0));
                        end else begin
                            e = sb.pop_front();
                            chk("pick_port", i, 32'(i), 32'(e.port));
                            chk("pick", i, 32'(o_output_req[i]), 32'(e.req));
                        end
                    end
                    prev[i] = o_output_req[i];
                end
                for (int d = 0; d < 4; d++)
                    chk("credit", d, 32'(o_credit[d]), 32'(m_cred[d]));
            end
        end
    end

    initial begin
        int r, cnt;
        i_reset = 1'b1;
        i_select_neighbor = '0; i_avail_directions = '0;
        i_flit_sent = '0; i_tail_sent = '0; i_credit_return = '0;
        tick(); tick();
        i_reset = 1'b0;
        mon_en  = 1'b1;
        for (int i = 0; i < N; i++) begin
            chk("rst_busy", i, 32'(o_busy[i]), 0);
            chk("rst_rv", i, 32'(o_req_valid[i]), 0);
            chk("rst_req", i, 32'(o_output_req[i]), 0);
        end
        for (int d = 0; d < 4; d++) chk("rst_credit", d, 32'(o_credit[d]), 4);
        tick();

        // Single-candidate list, E on port 1
        sel(1, 1, 0, 1); tick();
        chk("p1_busy_sel", 1, 32'(o_busy[1]), 1);
        chk("p1_req_sel", 1, 32'(o_output_req[1]), 0);
        tick();
        chk("p1_req", 1, 32'(o_output_req[1]), 32'b00100);
        chk("p1_rv", 1, 32'(o_req_valid[1]), 1);
        for (int d = 0; d < 4; d++) chk("p1_credit", d, 32'(o_credit[d]), 4);
        flit(1, 1); tick();
        chk("p1_idle", 1, 32'(o_busy[1]), 0);
        chk("p1_E_credit", 1, 32'(o_credit[1]), 3);
        ret(1); tick();
        chk("p1_E_ret", 1, 32'(o_credit[1]), 4);

        // Build N=1, E=3, then select on port 0 between N and E
        sel(3, 0, 0, 1); sel(4, 1, 0, 1); tick(); tick();
        flit(3, 0); flit(4, 0); tick();
        flit(3, 0); tick();
        flit(3, 0); tick();
        chk("pre_N", 0, 32'(o_credit[0]), 1);
        chk("pre_E", 1, 32'(o_credit[1]), 3);
        sel(0, 0, 1, 2); tick(); tick();
        chk("p0_pick_E", 0, 32'(o_output_req[0]), 32'b00100);
        flit(0, 1); ret(1); tick();
        chk("E_send_ret", 1, 32'(o_credit[1]), 3);
        ret(0); tick(); ret(0); tick();
        chk("tie_N", 0, 32'(o_credit[0]), 3);
        sel(0, 0, 1, 2); tick(); tick();
        chk("p0_pick_tie", 0, 32'(o_output_req[0]), 32'b01000);

        // A select during HOLD is ignored; the tail returns the port to IDLE
        sel(3, 2, 0, 1); tick(); tick();
        chk("p3_hold_req", 3, 32'(o_output_req[3]), 32'b01000);
        chk("p3_hold_busy", 3, 32'(o_busy[3]), 1);
        flit(3, 1); tick();
        chk("p3_tail_rv", 3, 32'(o_req_valid[3]), 0);
        chk("p3_tail_req", 3, 32'(o_output_req[3]), 0);
        chk("p3_tail_busy", 3, 32'(o_busy[3]), 0);
        flit(0, 1); tick();
        flit(4, 1); tick();

        // Drain the W credits on port 2
        sel(2, 3, 0, 1); tick(); tick();
        chk("p2_req", 2, 32'(o_output_req[2]), 32'b00001);
        chk("p2_rv", 2, 32'(o_req_valid[2]), 1);
        for (int k = 0; k < 4; k++) begin flit(2, 0); tick(); end
        chk("W_zero", 3, 32'(o_credit[3]), 0);
        chk("p2_rv_lag", 2, 32'(o_req_valid[2]), 1);
        tick();
        chk("p2_rv_drop", 2, 32'(o_req_valid[2]), 0);
        ret(3); tick();
        chk("W_one", 3, 32'(o_credit[3]), 1);
        chk("p2_rv_still0", 2, 32'(o_req_valid[2]), 0);
        tick();
        chk("p2_rv_back", 2, 32'(o_req_valid[2]), 1);
        flit(2, 1); tick();
        for (int k = 0; k < 4; k++) begin ret(3); tick(); end

        // Reset during HOLD
        sel(4, 3, 0, 1); tick(); tick();
        for (int k = 0; k < 3; k++) begin flit(4, 0); tick(); end
        chk("p4_W1", 3, 32'(o_credit[3]), 1);
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        chk("p4_rst_busy", 4, 32'(o_busy[4]), 0);
        chk("p4_rst_req", 4, 32'(o_output_req[4]), 0);
        for (int d = 0; d < 4; d++) chk("p4_rst_credit", d, 32'(o_credit[d]), 4);
        sel(4, 0, 0, 0); tick();
        chk("cnt0_busy", 4, 32'(o_busy[4]), 1);
        tick();
        chk("cnt0_idle", 4, 32'(o_busy[4]), 0);
        chk("cnt0_req", 4, 32'(o_output_req[4]), 0);
        chk("cnt0_rv", 4, 32'(o_req_valid[4]), 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 4; d++) used[d] = 0;
            for (int i = 0; i < N; i++) begin
                if (!m_pend[i] && !m_hold[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r = $urandom_range(0, 9);
                        cnt = (r == 0) ? 0 : (r == 1) ? 3 : (r < 6) ? 1 : 2;
                        sel(i, $urandom_range(0, 3), $urandom_range(0, 3), cnt);
                    end
                end else if (m_hold[i] && m_rv[i] && m_cred[m_dir[i]] > 0 &&
                             !used[m_dir[i]] && $urandom_range(0, 1) == 1) begin
                    used[m_dir[i]] = 1;
                    flit(i, $urandom_range(0, 3) == 0);
                end else if ($urandom_range(0, 7) == 0) begin
                    sel(i, $urandom_range(0, 3), $urandom_range(0, 3), 1);
                end
            end
            for (int d = 0; d < 4; d++)
                if (m_cred[d] < BUF_DEPTH && $urandom_range(0, 2) == 0) ret(d);
            if ($urandom_range(0, 599) == 0) i_reset = 1'b1;
            tick();
            i_reset = 1'b0;
        end
        tick(); tick();
        chk("sb_empty", 0, 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
